uart_fifo: RTL and testbench



---
 rtl/uart_fifo.sv | 205 ++++++++++++++++++++
 tb/tb_uart_fifo.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo.sv
// uart_fifo: buffered bus UART (TX/RX FIFOs, parity, 1/2 stop, sticky errors, CNT readout, maskable IRQ)
module uart_fifo #(
  parameter int          AW        = 4,
  parameter logic [15:0] DIV_RESET = 16'd26
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [4:2]  ADD_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  input  logic        STB_I,
  input  logic        WE_I,
  output logic        ACK_O,
  input  logic        RxD,
  output logic        TxD,
  output logic        IRQ
);
  localparam int D = 1 << AW;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t tx_st_q, tx_st_d, rx_st_q, rx_st_d;
  logic [2:0] lcr_q, lcr_d, ier_q, ier_d, tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [3:0] tx_tk_q, tx_tk_d, rx_tk_q, rx_tk_d, err_q, err_d;
  logic [15:0] div_q, div_d, bc_q, bc_d;
  logic [7:0] tx_dat_q, tx_dat_d, rx_dat_q, rx_dat_d;
  logic [7:0] tx_mem_q [D];
  logic [7:0] rx_mem_q [D];
  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d, rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [AW:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [1:0] sync_q, sync_d;
  logic rx_par_q, rx_par_d, irq_q, irq_d, rx_line;
  logic w_dat, w_lcr, w_div, w_ier, r_dat, r_lsr, tick, tx_end, rx_end;
  logic tx_full, tx_empty, rx_full, rx_empty, tx_idle;
  logic tx_push, tx_pop, rx_push, rx_pop, rx_push_req, fe_set, pe_set, unused_ok;
  assign unused_ok = ^DAT_I[31:16];
  assign w_dat = STB_I & WE_I & (ADD_I == 3'd0);
  assign w_lcr = STB_I & WE_I & (ADD_I == 3'd2);
  assign w_div = STB_I & WE_I & (ADD_I == 3'd3);
  assign w_ier = STB_I & WE_I & (ADD_I == 3'd4);
  assign r_dat = STB_I & ~WE_I & (ADD_I == 3'd0);
  assign r_lsr = STB_I & ~WE_I & (ADD_I == 3'd1);
  assign tick = bc_q == div_q;
  assign tx_full = tx_cnt_q[AW];
  assign rx_full = rx_cnt_q[AW];
  assign tx_empty = tx_cnt_q == '0;
  assign rx_empty = rx_cnt_q == '0;
  assign tx_idle = tx_empty & (tx_st_q == IDLE);
  assign tx_end = tick & (&tx_tk_q);
  assign rx_end = tick & (&rx_tk_q);
  assign rx_line = sync_q[1];
  assign ACK_O = STB_I;
  assign IRQ = irq_q;
  assign TxD = (tx_st_q == START) ? 1'b0 :
               (tx_st_q == DATA) ? tx_dat_q[tx_bit_q] :
               (tx_st_q == PARITY) ? ^tx_dat_q ^ lcr_q[1] : 1'b1;
  always_comb begin
    lcr_d = w_lcr ? DAT_I[2:0] : lcr_q;
    ier_d = w_ier ? DAT_I[2:0] : ier_q;
    div_d = w_div ? DAT_I[15:0] : div_q;
    bc_d = (w_div | tick) ? '0 : bc_q + 16'd1;
    sync_d = {sync_q[0], RxD};
    rx_pop = r_dat & ~rx_empty;
    tx_push = w_dat & (~tx_full | tx_pop);
    rx_push = rx_push_req & (~rx_full | rx_pop);
    tx_wp_d = tx_wp_q + AW'(tx_push);
    tx_rp_d = tx_rp_q + AW'(tx_pop);
    rx_wp_d = rx_wp_q + AW'(rx_push);
    rx_rp_d = rx_rp_q + AW'(rx_pop);
    tx_cnt_d = tx_cnt_q + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
    rx_cnt_d = rx_cnt_q + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
    err_d = (err_q & {4{~r_lsr}}) | {fe_set, pe_set, rx_push_req & ~rx_push, w_dat & ~tx_push};
    irq_d = (ier_q[0] & ~rx_empty) | (ier_q[1] & tx_empty) | (ier_q[2] & |err_q);
  end
  always_comb begin
    tx_st_d = tx_st_q;
    tx_tk_d = (tick && tx_st_q != IDLE) ? tx_tk_q + 4'd1 : tx_tk_q;
    tx_bit_d = tx_bit_q;
    tx_pop = 1'b0;
    case (tx_st_q)
      IDLE: if (tick && !tx_empty) begin
        tx_pop = 1'b1;
        tx_st_d = START;
        tx_tk_d = '0;
      end
      START: if (tx_end) begin
        tx_st_d = DATA;
        tx_bit_d = '0;
      end
      DATA: if (tx_end) begin
        tx_bit_d = tx_bit_q + 3'd1;
        tx_st_d = (tx_bit_q == 3'd7) ? (lcr_q[0] ? PARITY : STOP) : DATA;
      end
      PARITY: if (tx_end) tx_st_d = STOP;
      STOP: if (tx_end) begin
        if (lcr_q[2] && tx_bit_q == 3'd0) tx_bit_d = 3'd1;
        else if (!tx_empty) begin
          tx_pop = 1'b1;
          tx_st_d = START;
        end else tx_st_d = IDLE;
      end
      default: tx_st_d = IDLE;
    endcase
    tx_dat_d = tx_pop ? tx_mem_q[tx_rp_q] : tx_dat_q;
  end
  always_comb begin
    rx_st_d = rx_st_q;
    rx_tk_d = (tick && rx_st_q != IDLE) ? rx_tk_q + 4'd1 : rx_tk_q;
    rx_bit_d = rx_bit_q;
    rx_dat_d = rx_dat_q;
    rx_par_d = rx_par_q;
    rx_push_req = 1'b0;
    fe_set = 1'b0;
    pe_set = 1'b0;
    case (rx_st_q)
      IDLE: if (tick && !rx_line) begin
        rx_st_d = START;
        rx_tk_d = '0;
      end
      START: if (tick && rx_tk_q == 4'd7) begin
        rx_st_d = rx_line ? IDLE : DATA;
        rx_tk_d = '0;
        rx_bit_d = '0;
      end
      DATA: if (rx_end) begin
        rx_dat_d[rx_bit_q] = rx_line;
        rx_bit_d = rx_bit_q + 3'd1;
        rx_st_d = (rx_bit_q == 3'd7) ? (lcr_q[0] ? PARITY : STOP) : DATA;
      end
      PARITY: if (rx_end) begin
        rx_par_d = rx_line;
        rx_st_d = STOP;
      end
      STOP: if (rx_end) begin
        rx_push_req = 1'b1;
        fe_set = ~rx_line;
        pe_set = lcr_q[0] & (rx_par_q != (^rx_dat_q ^ lcr_q[1]));
        rx_st_d = IDLE;
      end
      default: rx_st_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      lcr_q <= '0;
      ier_q <= '0;
      div_q <= DIV_RESET;
      bc_q <= '0;
      err_q <= '0;
      irq_q <= 1'b0;
      sync_q <= 2'b11;
      tx_wp_q <= '0;
      tx_rp_q <= '0;
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      tx_st_q <= IDLE;
      rx_st_q <= IDLE;
      tx_tk_q <= '0;
      rx_tk_q <= '0;
      tx_bit_q <= '0;
      rx_bit_q <= '0;
      tx_dat_q <= '0;
      rx_dat_q <= '0;
      rx_par_q <= 1'b0;
    end else begin
      lcr_q <= lcr_d;
      ier_q <= ier_d;
      div_q <= div_d;
      bc_q <= bc_d;
      err_q <= err_d;
      irq_q <= irq_d;
      sync_q <= sync_d;
      tx_wp_q <= tx_wp_d;
      tx_rp_q <= tx_rp_d;
      rx_wp_q <= rx_wp_d;
      rx_rp_q <= rx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      tx_st_q <= tx_st_d;
      rx_st_q <= rx_st_d;
      tx_tk_q <= tx_tk_d;
      rx_tk_q <= rx_tk_d;
      tx_bit_q <= tx_bit_d;
      rx_bit_q <= rx_bit_d;
      tx_dat_q <= tx_dat_d;
      rx_dat_q <= rx_dat_d;
      rx_par_q <= rx_par_d;
    end
  end
  always_ff @(posedge CLK_I) begin
    if (tx_push) tx_mem_q[tx_wp_q] <= DAT_I[7:0];
    if (rx_push) rx_mem_q[rx_wp_q] <= rx_dat_q;
  end
  always_comb begin
    case (ADD_I)
      3'd0: DAT_O = {24'b0, rx_empty ? 8'h00 : rx_mem_q[rx_rp_q]};
      3'd1: DAT_O = {26'b0, tx_idle, tx_full, err_q[3], err_q[2], |err_q[1:0], ~rx_empty};
      3'd2: DAT_O = {29'b0, lcr_q};
      3'd3: DAT_O = {16'b0, div_q};
      3'd4: DAT_O = {29'b0, ier_q};
      3'd5: DAT_O = {16'(tx_cnt_q), 16'(rx_cnt_q)};
      default: DAT_O = '0;
    endcase
  end
endmodule

// File: tb/tb_uart_fifo.sv
// tb_uart_fifo: directed scoreboard bench for uart_fifo (depth-4 FIFOs)
module tb_uart_fifo;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, stb, we, rxd_drv, loop, ack, txd, irq, rxd;
  logic [2:0] add;
  logic [31:0] dat_i, dat_o, rdata;
  logic [7:0] sb [$];
  logic [7:0] pat;
  int tests = 0, fails = 0, n, len;
  assign rxd = loop ? txd : rxd_drv;
  uart_fifo #(.AW(2), .DIV_RESET(16'd26)) dut (
    .CLK_I(clk), .RST_I(rst), .ADD_I(add), .DAT_I(dat_i), .DAT_O(dat_o),
    .STB_I(stb), .WE_I(we), .ACK_O(ack), .RxD(rxd), .TxD(txd), .IRQ(irq)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    add = a;
    dat_i = d;
    we = 1'b1;
    stb = 1'b1;
    @(negedge clk);
    stb = 1'b0;
    we = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    add = a;
    we = 1'b0;
    stb = 1'b1;
    #1 d = dat_o;
    @(negedge clk);
    stb = 1'b0;
  endtask
  task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, exp);
  endtask
  task automatic rd_sb(input string tag);
    logic [31:0] d;
    rd(3'd0, d);
    if (sb.size() == 0) chk({tag, "_sb_underflow"}, d, 32'hxxxx_xxxx);
    else chk(tag, d, {24'b0, sb.pop_front()});
  endtask
  task automatic send_rx(input logic [7:0] b, input logic par_en, input logic par, input logic stop);
    rxd_drv = 1'b0;
    cycles(16);
    for (int i = 0; i < 8; i++) begin
      rxd_drv = b[i];
      cycles(16);
    end
    if (par_en) begin
      rxd_drv = par;
      cycles(16);
    end
    rxd_drv = stop;
    cycles(16);
    rxd_drv = 1'b1;
    cycles(32);
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask
  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    stb = 1'b0;
    we = 1'b0;
    add = '0;
    dat_i = '0;
    rxd_drv = 1'b1;
    loop = 1'b0;
    cycles(3);
    rst = 1'b0;
    chk("txd_rst", txd, 1'b1);
    chk("irq_rst", irq, 1'b0);
    rd_chk(3'd1, 32'h20, "lsr_rst");
    rd_chk(3'd2, 32'h0, "lcr_rst");
    rd_chk(3'd3, 32'd26, "div_rst");
    rd_chk(3'd4, 32'h0, "ier_rst");
    rd_chk(3'd5, 32'h0, "cnt_rst");
    rd_chk(3'd7, 32'h0, "unmapped");
    rd_chk(3'd0, 32'h0, "data_empty");
    @(negedge clk);
    add = 3'd7;
    stb = 1'b1;
    #1 chk("ack_on", ack, 1'b1);
    @(negedge clk);
    stb = 1'b0;
    #1 chk("ack_off", ack, 1'b0);
    wr(3'd3, 32'h0);
    wr(3'd2, 32'h0);
    rd_chk(3'd3, 32'h0, "div_wr");
    pat = 8'hA5;
    wr(3'd0, {24'b0, pat});
    n = 0;
    while (txd !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("tx_start_seen", txd, 1'b0);
    len = 0;
    while (txd === 1'b0 && len < 40) begin
      @(negedge clk);
      len++;
    end
    chk("tx_start_len", len, 16);
    cycles(7);
    for (int i = 0; i < 8; i++) begin
      chk("tx_bit", txd, pat[i]);
      cycles(16);
    end
    chk("tx_stop", txd, 1'b1);
    cycles(20);
    rd_chk(3'd1, 32'h20, "lsr_tx_done");
    loop = 1'b1;
    wr(3'd2, 32'h3);
    foreach (pat[i]) pat[i] = 1'b0;
    sb.push_back(8'h3C);
    wr(3'd0, 32'h3C);
    sb.push_back(8'h00);
    wr(3'd0, 32'h00);
    sb.push_back(8'hFF);
    wr(3'd0, 32'hFF);
    n = 0;
    rd(3'd5, rdata);
    while (rdata !== 32'h3 && n < 3000) begin
      rd(3'd5, rdata);
      n++;
    end
    chk("lb_cnt", rdata, 32'h3);
    cycles(20);
    rd_chk(3'd1, 32'h21, "lb_lsr");
    for (int i = 0; i < 3; i++) rd_sb("lb_data");
    rd_chk(3'd1, 32'h20, "lb_lsr_empty");
    loop = 1'b0;
    wr(3'd2, 32'h0);
    wr(3'd3, 32'hFFFF);
    for (int i = 0; i < 6; i++) wr(3'd0, 32'(i));
    rd_chk(3'd5, 32'h0004_0000, "tx_cnt_full");
    rd_chk(3'd1, 32'h12, "lsr_txovf");
    rd_chk(3'd1, 32'h10, "lsr_txovf_clr");
    do_reset();
    rd_chk(3'd5, 32'h0, "cnt_after_rst");
    rd_chk(3'd3, 32'd26, "div_after_rst");
    wr(3'd4, 32'h2);
    cycles(2);
    chk("irq_txempty", irq, 1'b1);
    wr(3'd4, 32'h0);
    cycles(2);
    chk("irq_masked", irq, 1'b0);
    wr(3'd3, 32'h0);
    for (int i = 0; i < 5; i++) begin
      pat = 8'h11 * 8'(i + 1);
      if (i < 4) sb.push_back(pat);
      send_rx(pat, 1'b0, 1'b0, 1'b1);
    end
    rd_chk(3'd5, 32'h4, "rx_cnt_full");
    wr(3'd4, 32'h4);
    cycles(2);
    chk("irq_err", irq, 1'b1);
    rd_chk(3'd1, 32'h23, "lsr_rxovf");
    cycles(2);
    chk("irq_cleared", irq, 1'b0);
    rd_chk(3'd1, 32'h21, "lsr_rxovf_clr");
    for (int i = 0; i < 4; i++) rd_sb("rx_data");
    rd_chk(3'd0, 32'h0, "data_empty2");
    rd_chk(3'd5, 32'h0, "cnt_drained");
    wr(3'd4, 32'h0);
    sb.push_back(8'h5A);
    send_rx(8'h5A, 1'b0, 1'b0, 1'b0);
    rd_chk(3'd1, 32'h29, "lsr_fe");
    rd_sb("fe_data");
    rd_chk(3'd1, 32'h20, "lsr_fe_clr");
    wr(3'd2, 32'h1);
    sb.push_back(8'h01);
    send_rx(8'h01, 1'b1, 1'b0, 1'b1);
    rd_chk(3'd1, 32'h25, "lsr_pe");
    rd_sb("pe_data");
    sb.push_back(8'h03);
    send_rx(8'h03, 1'b1, 1'b0, 1'b1);
    rd_chk(3'd1, 32'h21, "lsr_par_ok");
    rd_sb("par_ok_data");
    wr(3'd2, 32'h0);
    wr(3'd0, 32'h00);
    wr(3'd0, 32'h00);
    n = 0;
    while (txd !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_start_seen", txd, 1'b0);
    cycles(36);
    rd_chk(3'd5, 32'h0001_0000, "cnt_midframe");
    chk("txd_midframe", txd, 1'b0);
    do_reset();
    chk("txd_midrst", txd, 1'b1);
    rd_chk(3'd5, 32'h0, "cnt_midrst");
    rd_chk(3'd1, 32'h20, "lsr_midrst");
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
